// File: rtl/icache_fetch_data_wrap.sv
// icache_fetch_data_wrap: N-way I-cache data stage with tree-PLRU victim choice and critical-word-first WRAP refill.
// Define ICACHE_EARLY_RESTART_EN to forward the critical word to decode while the refill is still in progress.
module icache_fetch_data_wrap #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 64,
    parameter int CL_BYTES = 32,
    localparam int OFF_BITS = $clog2(CL_BYTES),
    localparam int SET_BITS = $clog2(NUM_SETS),
    localparam int TAG_W = 32 - SET_BITS - OFF_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_do_branch,
    input  logic                      req_valid,
    input  logic [31:0]               req_pc,
    input  logic [NUM_WAYS-1:0]       tag_valid,
    input  logic [NUM_WAYS*TAG_W-1:0] tags_read,
    output logic [31:0]               axi_araddr,
    output logic [7:0]                axi_arlen,
    output logic [2:0]                axi_arsize,
    output logic [1:0]                axi_arburst,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic [31:0]               axi_rdata,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rvalid,
    input  logic                      axi_rlast,
    output logic                      axi_rready,
    output logic                      cache_miss,
    output logic                      resume_fetch,
    output logic                      resume_skip,
    output logic [NUM_WAYS-1:0]       update_tag_en,
    output logic [SET_BITS-1:0]       update_tag_set,
    output logic [TAG_W-1:0]          update_tag,
    output logic                      instr_valid,
    output logic [31:0]               instr,
    output logic [31:0]               instr_pc,
    output logic [31:0]               instr_pc_inc
);
    localparam int WORDS = CL_BYTES / 4;
    localparam int WIDX = $clog2(WORDS);
    localparam int LEVELS = $clog2(NUM_WAYS);
    localparam int WAY_BITS = LEVELS > 0 ? LEVELS : 1;
    localparam int TREE_W = NUM_WAYS > 1 ? NUM_WAYS - 1 : 1;
    localparam int RAM_D = (1 << WAY_BITS) * NUM_SETS;

    typedef enum logic [1:0] {IDLE, ISSUE_ADDR, FETCH, REFILL} state_t;

    state_t state, state_nx;
    logic [NUM_WAYS-1:0] hit_w;
    logic hit, early_fire, kill, delivered, unused;
    logic [WAY_BITS-1:0] hit_way, victim;
    logic [31:0] miss_pc;
    logic [WIDX-1:0] beat;
    logic [TREE_W-1:0] plru [NUM_SETS];
    logic [WORDS-1:0][31:0] line_buf;
    logic [WORDS-1:0][31:0] line_ram [RAM_D];

    wire [TAG_W-1:0]    req_tag  = req_pc[31 -: TAG_W];
    wire [SET_BITS-1:0] req_set  = req_pc[OFF_BITS +: SET_BITS];
    wire [WIDX-1:0]     req_word = req_pc[OFF_BITS-1:2];
    wire [SET_BITS-1:0] miss_set = miss_pc[OFF_BITS +: SET_BITS];
    wire [WIDX-1:0]     crit_idx = miss_pc[OFF_BITS-1:2];

    // Heap-ordered tree: node n has children 2n and 2n+1; a node bit points toward the victim half.
    function automatic logic [WAY_BITS-1:0] plru_victim(input logic [TREE_W-1:0] t);
        logic [WAY_BITS-1:0] v = '0;
        int n = 1;
        for (int l = 0; l < LEVELS; l++) begin
            v[LEVELS-1-l] = t[n-1];
            n = 2 * n + int'(t[n-1]);
        end
        return v;
    endfunction

    function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] t, input logic [WAY_BITS-1:0] w);
        logic [TREE_W-1:0] r = t;
        int n = 1;
        for (int l = 0; l < LEVELS; l++) begin
            r[n-1] = ~w[LEVELS-1-l];
            n = 2 * n + int'(w[LEVELS-1-l]);
        end
        return r;
    endfunction

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_hit
        assign hit_w[g] = tag_valid[g] && tags_read[g*TAG_W +: TAG_W] == req_tag;
    end

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (hit_w[w]) hit_way = WAY_BITS'(w);
    end

    assign hit = |hit_w;
    assign cache_miss = req_valid && !wb_do_branch && !hit && state == IDLE;
    assign unused = ^axi_rresp;

`ifdef ICACHE_EARLY_RESTART_EN
    assign early_fire = state == FETCH && axi_rvalid && beat == '0 && !kill && !wb_do_branch;
`else
    assign early_fire = 1'b0;
`endif

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:       state_nx = cache_miss ? ISSUE_ADDR : IDLE;
            ISSUE_ADDR: state_nx = axi_arready ? FETCH : ISSUE_ADDR;
            FETCH:      state_nx = axi_rvalid && axi_rlast ? REFILL : FETCH;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        axi_arvalid    = state == ISSUE_ADDR;
        axi_araddr     = {miss_pc[31:2], 2'b00};
        axi_arlen      = 8'(WORDS - 1);
        axi_arsize     = 3'b010;
        axi_arburst    = 2'b10;
        axi_rready     = 1'b1;
        update_tag_en  = state == REFILL ? NUM_WAYS'(1) << victim : '0;
        update_tag_set = miss_set;
        update_tag     = miss_pc[31 -: TAG_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_valid  <= 1'b0;
            resume_fetch <= 1'b0;
            resume_skip  <= 1'b0;
            kill         <= 1'b0;
            delivered    <= 1'b0;
        end else begin
            instr_valid  <= (req_valid && hit && !wb_do_branch) || early_fire;
            resume_fetch <= state == REFILL;
            resume_skip  <= state == REFILL && delivered;
            kill         <= state != IDLE && (kill || wb_do_branch);
            delivered    <= state != IDLE && (delivered || early_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) plru[s] <= '0;
        end else begin
            if (state == REFILL) plru[miss_set] <= plru_touch(plru[miss_set], victim);
            if (req_valid && hit) plru[req_set] <= plru_touch(plru[req_set], hit_way);
        end
    end

    // Datapath needs no reset: every register here is qualified by the FSM before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && cache_miss) begin
            miss_pc <= req_pc;
            victim  <= plru_victim(plru[req_set]);
        end
        if (state == ISSUE_ADDR && axi_arready) beat <= '0;
        if (state == FETCH && axi_rvalid) begin
            line_buf[WIDX'(crit_idx + beat)] <= axi_rdata;
            beat <= beat + 1'b1;
        end
        if (!rst && state == REFILL) line_ram[{victim, miss_set}] <= line_buf;
        if (early_fire) begin
            instr        <= axi_rdata;
            instr_pc     <= miss_pc;
            instr_pc_inc <= miss_pc + 32'd4;
        end else begin
            instr        <= line_ram[{hit_way, req_set}][req_word];
            instr_pc     <= req_pc;
            instr_pc_inc <= req_pc + 32'd4;
        end
    end

    assert property (@(posedge clk) disable iff (rst) req_valid |-> $onehot0(hit_w));
    assert property (@(posedge clk) disable iff (rst)
        state == FETCH && axi_rvalid && axi_rlast |-> beat == WIDX'(WORDS - 1));
endmodule

// File: tb/tb_icache_fetch_data_wrap.sv
// tb_icache_fetch_data_wrap: directed misses/hits against a tag-store, PLRU and memory model with a queued scoreboard.
module tb_icache_fetch_data_wrap;
    localparam int NW = 4, NS = 64, CLB = 32, TW = 21, WORDS = 8;

    logic clk = 1'b0, rst = 1'b1, wb_do_branch = 1'b0, req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic [NW-1:0] tag_valid = '0;
    logic [NW*TW-1:0] tags_read = '0;
    logic [31:0] axi_araddr, axi_rdata = '0;
    logic [7:0] axi_arlen;
    logic [2:0] axi_arsize;
    logic [1:0] axi_arburst, axi_rresp = 2'b00;
    logic axi_arvalid, axi_arready = 1'b0, axi_rvalid = 1'b0, axi_rlast = 1'b0, axi_rready;
    logic cache_miss, resume_fetch, resume_skip, instr_valid;
    logic [NW-1:0] update_tag_en;
    logic [5:0] update_tag_set;
    logic [TW-1:0] update_tag;
    logic [31:0] instr, instr_pc, instr_pc_inc;

    icache_fetch_data_wrap #(.NUM_WAYS(NW), .NUM_SETS(NS), .CL_BYTES(CLB)) dut (
        .clk(clk), .rst(rst), .wb_do_branch(wb_do_branch), .req_valid(req_valid), .req_pc(req_pc),
        .tag_valid(tag_valid), .tags_read(tags_read), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rready(axi_rready),
        .cache_miss(cache_miss), .resume_fetch(resume_fetch), .resume_skip(resume_skip),
        .update_tag_en(update_tag_en), .update_tag_set(update_tag_set), .update_tag(update_tag),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_pc_inc(instr_pc_inc)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] instr, pc, inc; int cyc;} ins_t;
    typedef struct {logic [NW-1:0] en; logic [5:0] set; logic [TW-1:0] tag; int cyc;} ref_t;
    typedef struct {logic skip; int cyc;} res_t;

    ins_t instr_q[$];
    ref_t ref_q[$];
    res_t res_q[$];
    logic miss_q[$];
    logic [31:0] ar_q[$];
    ins_t ei;
    ref_t er;
    res_t es;

    int checks = 0, errors = 0, ncyc = 0;
    logic [TW-1:0] tagm [NW][NS];
    logic vm [NW][NS];
    logic [2:0] tr [NS];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endfunction

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'h4010 ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'h0123_4567;
    endfunction

    // Reference 3-bit tree: [0] root, [1] ways 0/1, [2] ways 2/3; a bit names the half to evict.
    function automatic logic [1:0] victim(input logic [5:0] s);
        return !tr[s][0] ? {1'b0, tr[s][1]} : {1'b1, tr[s][2]};
    endfunction

    function automatic void touch(input logic [5:0] s, input logic [1:0] w);
        tr[s][0] = ~w[1];
        if (w[1]) tr[s][2] = ~w[0];
        else tr[s][1] = ~w[0];
    endfunction

    always @(negedge clk) begin
        ncyc++;
        if (req_valid) begin
            if (miss_q.size() == 0) chk("cache_miss_unexpected_req", {31'd0, req_valid}, 32'd0);
            else chk("cache_miss", {31'd0, cache_miss}, {31'd0, miss_q.pop_front()});
        end
        if (instr_valid) begin
            if (instr_q.size() == 0) chk("instr_valid_unexpected", {31'd0, instr_valid}, 32'd0);
            else begin
                ei = instr_q.pop_front();
                chk("instr", instr, ei.instr);
                chk("instr_pc", instr_pc, ei.pc);
                chk("instr_pc_inc", instr_pc_inc, ei.inc);
                chk("instr_cycle", ncyc, ei.cyc);
            end
        end
        if (|update_tag_en) begin
            if (ref_q.size() == 0) chk("update_tag_en_unexpected", {28'd0, update_tag_en}, 32'd0);
            else begin
                er = ref_q.pop_front();
                chk("update_tag_en", {28'd0, update_tag_en}, {28'd0, er.en});
                chk("update_tag_set", {26'd0, update_tag_set}, {26'd0, er.set});
                chk("update_tag", {11'd0, update_tag}, {11'd0, er.tag});
                chk("update_cycle", ncyc, er.cyc);
            end
        end
        if (resume_fetch) begin
            if (res_q.size() == 0) chk("resume_fetch_unexpected", {31'd0, resume_fetch}, 32'd0);
            else begin
                es = res_q.pop_front();
                chk("resume_skip", {31'd0, resume_skip}, {31'd0, es.skip});
                chk("resume_cycle", ncyc, es.cyc);
            end
        end
        if (axi_arvalid && axi_arready) begin
            if (ar_q.size() == 0) chk("ar_unexpected", {31'd0, axi_arvalid}, 32'd0);
            else begin
                chk("araddr", axi_araddr, ar_q.pop_front());
                chk("arlen", {24'd0, axi_arlen}, 32'd7);
                chk("arburst", {30'd0, axi_arburst}, 32'd2);
                chk("arsize", {29'd0, axi_arsize}, 32'd2);
            end
        end
    end

    // One IFT request; on a miss, plays the AXI slave (optional branch beat br, reset before beat rb).
    task automatic access(input logic [31:0] pc, input int br, input int rb);
        logic [5:0] s;
        logic [TW-1:0] t;
        logic [1:0] vic;
        logic [31:0] base;
        logic dlv;
        int hw, crit;
        ins_t e;
        ref_t r;
        res_t q;
        s = pc[10:5];
        t = pc[31:11];
        hw = -1;
        for (int w = 0; w < NW; w++) begin
            tag_valid[w] = vm[w][s];
            tags_read[w*TW +: TW] = tagm[w][s];
            if (vm[w][s] && tagm[w][s] == t) hw = w;
        end
        req_pc = pc;
        req_valid = 1'b1;
        miss_q.push_back(hw < 0);
        vic = victim(s);
        if (hw >= 0) begin
            e.instr = mem(pc); e.pc = pc; e.inc = pc + 32'd4; e.cyc = ncyc + 2;
            instr_q.push_back(e);
            touch(s, 2'(hw));
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (hw >= 0) return;
        ar_q.push_back(pc);
        for (int i = 0; i < 20 && !axi_arvalid; i++) begin
            @(posedge clk); #1;
        end
        chk("arvalid_within_bound", {31'd0, axi_arvalid}, 32'd1);
        if (!axi_arvalid) return;
        axi_arready = 1'b1;
        @(posedge clk); #1;
        axi_arready = 1'b0;
        base = {pc[31:5], 5'd0};
        crit = int'(pc[4:2]);
        dlv = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            if (i == rb) begin
                axi_rvalid = 1'b0; axi_rlast = 1'b0; wb_do_branch = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                for (int k = 0; k < NS; k++) tr[k] = 3'd0;
                chk("arvalid_after_reset", {31'd0, axi_arvalid}, 32'd0);
                return;
            end
            axi_rvalid = 1'b1;
            axi_rdata = mem(base + 32'((crit + i) % WORDS) * 32'd4);
            axi_rlast = i == WORDS - 1;
            wb_do_branch = i == br;
`ifdef ICACHE_EARLY_RESTART_EN
            if (i == 0 && br != 0) begin
                e.instr = axi_rdata; e.pc = pc; e.inc = pc + 32'd4; e.cyc = ncyc + 2;
                instr_q.push_back(e);
                dlv = 1'b1;
            end
`endif
            if (i == WORDS - 1) begin
                r.en = NW'(1) << vic; r.set = s; r.tag = t; r.cyc = ncyc + 2;
                ref_q.push_back(r);
                q.skip = dlv; q.cyc = ncyc + 3;
                res_q.push_back(q);
            end
            @(posedge clk); #1;
        end
        axi_rvalid = 1'b0; axi_rlast = 1'b0; wb_do_branch = 1'b0;
        vm[vic][s] = 1'b1;
        tagm[vic][s] = t;
        touch(s, vic);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++) begin
                vm[w][s] = 1'b0;
                tagm[w][s] = '0;
            end
        for (int s = 0; s < NS; s++) tr[s] = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_arvalid", {31'd0, axi_arvalid}, 32'd0);
        chk("reset_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("reset_resume_fetch", {31'd0, resume_fetch}, 32'd0);
        chk("reset_resume_skip", {31'd0, resume_skip}, 32'd0);
        chk("reset_update_tag_en", {28'd0, update_tag_en}, 32'd0);
        chk("rready_tied", {31'd0, axi_rready}, 32'd1);
        // Critical-word-first refill, then hits on the critical word and both line ends.
        access(32'h1014, -1, -1);
        access(32'h1014, -1, -1);
        access(32'h1000, -1, -1);
        access(32'h101C, -1, -1);
        // Fill all four ways of set 3, touch way 0, then miss again.
        access(32'h0860, -1, -1);
        access(32'h1064, -1, -1);
        access(32'h1868, -1, -1);
        access(32'h207C, -1, -1);
        access(32'h0864, -1, -1);
        access(32'h2870, -1, -1);
        access(32'h2870, -1, -1);
        access(32'h207C, -1, -1);
        // Branch on beat 3: the line is still installed.
        access(32'h2048, 3, -1);
        access(32'h2048, -1, -1);
        // Reset after two beats: nothing installed, same PC misses again.
        access(32'h3008, -1, 2);
        access(32'h3008, -1, -1);
        access(32'h3008, -1, -1);
        access(32'h4010, -1, -1);
        access(32'h4010, -1, -1);
        access(32'h1018, -1, -1);
        repeat (6) @(posedge clk);
        #1;
        chk("instr_q_drained", instr_q.size(), 32'd0);
        chk("ref_q_drained", ref_q.size(), 32'd0);
        chk("res_q_drained", res_q.size(), 32'd0);
        chk("ar_q_drained", ar_q.size(), 32'd0);
        chk("miss_q_drained", miss_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/icache_fetch_data_wrap.md
Name: icache_fetch_data_wrap

Overview:
- Data stage of the parametrised N-way instruction cache. Sits between the tag-read stage (IFT) and decode (ID).
- Compares tags, reads the hit line from internal line RAM and delivers the 32-bit instruction to ID.
- On a miss, refills the line over AXI4 read using a critical-word-first WRAP burst, and picks the victim way with tree pseudo-LRU.
- Generalises the fixed-geometry, round-robin, INCR-refill data stage.

Parameters:
- NUM_WAYS, 4, associativity; power of two, 1..8.
- NUM_SETS, 64, sets per way; power of two ≥2.
- CL_BYTES, 32, line size in bytes; CL_BYTES/4 ∈ {2,4,8,16} (AXI WRAP legal).
- Derived:
  - OFF_BITS = log2(CL_BYTES)
  - SET_BITS = log2(NUM_SETS)
  - TAG_W = 32-SET_BITS-OFF_BITS
  - WORDS = CL_BYTES/4
  - WAY_BITS = max(1, log2(NUM_WAYS))

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_do_branch  in  1  redirect from writeback; kills in-flight delivery
- req_valid  in  1  IFT output valid
- req_pc  in  32  fetched PC (word aligned)
- tag_valid  in  NUM_WAYS  per-way valid bits read in IFT
- tags_read  in  NUM_WAYS*TAG_W  per-way tags; way w at [w*TAG_W +: TAG_W]
- axi_araddr  out  32  read address
- axi_arlen  out  8  WORDS-1
- axi_arsize  out  3  3'b010
- axi_arburst  out  2  2'b10 (WRAP)
- axi_arvalid  out  1  read address valid
- axi_arready  in  1  read address ready
- axi_rdata  in  32  read data
- axi_rresp  in  2  ignored
- axi_rvalid  in  1  read data valid
- axi_rlast  in  1  last beat
- axi_rready  out  1  tied 1
- cache_miss  out  1  combinational miss indication to IFT (stall)
- resume_fetch  out  1  one-cycle pulse: IFT may resume
- resume_skip  out  1  qualifies resume_fetch: missed instruction already delivered
- update_tag_en  out  NUM_WAYS  one-hot tag/valid write enable to IFT
- update_tag_set  out  SET_BITS  set to update
- update_tag  out  TAG_W  tag to write
- instr_valid  out  1  instruction valid to ID
- instr  out  32  instruction
- instr_pc  out  32  its PC
- instr_pc_inc  out  32  PC+4 (mod 2^32)

Behaviour:
- Hit detection:
  - hit_w = tag_valid[w] && tags_read[w] == req_pc tag field.
  - hit = |hit_w; multiple hits are illegal (assertion).
  - cache_miss = req_valid && !wb_do_branch && !hit && state==IDLE.
- Hit path:
  - Line RAM has 1-cycle read latency, addressed {hit_way, set}.
  - Cycle after req_valid&&hit: instr_valid=1, with instr = word req_pc[OFF_BITS-1:2] of the line, instr_pc=req_pc, instr_pc_inc=req_pc+4.
  - wb_do_branch forces instr_valid=0 next cycle.
- PLRU:
  - One NUM_WAYS-1-bit tree per set.
  - Updated to point away from the hit way on every valid hit, and away from the filled way at refill.
  - Victim = way indicated by the tree.
  - NUM_WAYS=1: victim always 0, no storage.
  - All trees clear to 0 on rst.
- FSM:
  - IDLE: on cache_miss, latch miss_pc, victim way and word index; assert arvalid; go to ISSUE_ADDR.
  - ISSUE_ADDR: araddr = miss_pc word-aligned (critical word first). On arready, drop arvalid, reset beat count; go to FETCH.
  - FETCH: each rvalid beat writes the line buffer at word (crit_idx + beat) mod WORDS. On rlast, go to REFILL.
  - REFILL (1 cycle): write line RAM {victim, set}; update_tag_en = onehot(victim); update_tag_set/update_tag from miss_pc; update PLRU; go to IDLE.
  - Cycle after REFILL: resume_fetch=1 for exactly one cycle.
- Latency: miss at cycle N → arvalid at N+1; rlast at R → update_tag_en at R+1 → resume_fetch at R+2.
- wb_do_branch during ISSUE_ADDR/FETCH/REFILL: the burst always completes and the line is installed. The branch only sets a kill flag, which is cleared in IDLE.
- rlast before WORDS beats is a protocol error (assertion). Extra beats in IDLE are ignored.
- Reset mid-burst: FSM→IDLE, arvalid=0. Outstanding beats are discarded; the line RAM is not written.
- Reset values: instr_valid, axi_arvalid, resume_fetch, resume_skip, update_tag_en = 0. instr, instr_pc, instr_pc_inc are don't-care.

Optional Feature:
- ICACHE_EARLY_RESTART_EN defined:
  - The cycle after the first beat (the critical word) arrives: instr_valid=1, instr=rdata, instr_pc=miss_pc, provided the kill flag is clear and wb_do_branch is 0 that cycle.
  - The later resume_fetch carries resume_skip=1 when that delivery happened; IFT then resumes at miss_pc+4.
- Undefined: no delivery during refill; resume_skip tied 0; IFT refetches miss_pc and hits.

Test Plan:
- Hit: 2-way, way1 valid with tag T, req_pc in T → instr_valid next cycle, instr = RAM word, instr_pc_inc = pc+4.
- Critical-word miss: CL_BYTES=32, pc=0x1014 → araddr 0x1014, arburst 2'b10, arlen 7. Beats land at words 5,6,7,0..4. update_tag_en = onehot(victim) at R+1; resume_fetch at R+2; refetch returns the word at 0x1014.
- PLRU: 4 ways, set 3. Fill ways by misses, then hit way0. Next miss victimises the PLRU-selected way (≠0); verify against a reference tree model.
- Branch during FETCH: wb_do_branch on beat 3 → line still installed, resume_fetch pulses, resume_skip=0, no instr_valid during the refill.
- Early restart (macro on): first beat 0xDEADBEEF → instr_valid=1, instr=0xDEADBEEF, instr_pc=miss_pc next cycle; resume_skip=1 with resume_fetch.
- Reset during FETCH after 2 beats → arvalid=0, FSM idle, no update_tag_en. Next access to the same PC misses again.
